// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying the words drained from the synchronous FIFO.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream through a
// 2-entry buffer that tracks the read in flight, so the FIFO is never over-read.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    fifo_stream_reader_if.master  m,
    input  logic                  flush,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  words_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            buf_count;
    logic                  inflight;

    logic                  valid_int;
    logic                  pop;
    logic                  capture;
    logic [2:0]            occupancy;

    assign valid_int = (buf_count != 2'd0);
    assign pop       = valid_int && m.m_ready;
    assign capture   = inflight && !flush;
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight};

    // A read may only be issued when its word is guaranteed a slot on return,
    // counting the word already in flight; a same-cycle pop frees one slot.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst_n && !flush && !fifo_empty) begin
            if (occupancy < 3'd2) begin
                fifo_rd_en = 1'b1;
            end else if ((occupancy == 3'd2) && pop) begin
                fifo_rd_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= 1'b0;
            head       <= 1'b0;
            tail       <= 1'b0;
            buf_count  <= 2'd0;
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
        end else if (flush) begin
            inflight  <= 1'b0;
            head      <= 1'b0;
            tail      <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            inflight <= fifo_rd_en;
            if (capture) begin
                buf_mem[tail] <= fifo_rd_data;
                tail          <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({capture, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // A word accepted in the flush cycle still left the block, so it is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out <= '0;
        end else if (pop) begin
            words_out <= words_out + CNT_ONE;
        end
    end

    assign m.m_valid = valid_int;
    assign m.m_data  = buf_mem[head];
    assign buf_level = buf_count;

endmodule
